// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage with request FSM and decode queue
//
// Purpose: issues one instruction-memory request at a time from the current
// fetch PC, buffers returned instructions with their PCs in a DEPTH-entry
// circular queue, presents the queue head to decode, drives the sequential
// next-PC back to the PC register and flushes everything on a taken branch.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   F_pc              current fetch PC from the PC register
//   EX_taken          taken branch/jump from EX, flushes this stage
//   pc_next           sequential next PC (advances only on an accepted request)
//   imem_req_valid/ready/addr   instruction-memory request handshake
//   imem_rsp_valid/data         instruction-memory response
//   D_valid/ready/instr/pc      queue head towards decode

module fetch_queue #(
  parameter int XLEN    = 5,
  parameter int ILEN    = 32,
  parameter int DEPTH   = 2,
  parameter int PC_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] F_pc,
  input  logic            EX_taken,
  output logic [XLEN-1:0] pc_next,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            D_valid,
  input  logic            D_ready,
  output logic [ILEN-1:0] D_instr,
  output logic [XLEN-1:0] D_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_req_pc;

  logic [ILEN-1:0] r_mem_instr [DEPTH];
  logic [XLEN-1:0] r_mem_pc    [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic            w_req_valid;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_d_valid;

  // Gated by rst_n so no request is presented while the block is held in reset.
  assign w_req_valid = rst_n && (r_state == S_REQ) && (r_count < CW'(DEPTH)) && !EX_taken;
  assign w_accept    = w_req_valid && imem_req_ready;
  assign w_d_valid   = (r_count != '0);
  assign w_pop       = w_d_valid && D_ready;

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = F_pc;
  assign D_valid        = w_d_valid;
  assign D_instr        = r_mem_instr[r_head];
  assign D_pc           = r_mem_pc[r_head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_REQ;
      r_req_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_req_pc <= F_pc;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    pc_next     = F_pc;
    if (w_accept) begin
      pc_next = F_pc + XLEN'(PC_STEP);
    end
    case (r_state)
      S_REQ: begin
        // A response here has no matching request and is simply ignored.
        if (w_accept) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (EX_taken) begin
          // A response arriving with the flush retires the request; otherwise
          // the still-pending response is stale and must be drained.
          w_state_nxt = imem_rsp_valid ? S_REQ : S_DRAIN;
        end else if (imem_rsp_valid) begin
          w_push      = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_DRAIN: begin
        // The stale response is dropped; once it arrives nothing is outstanding.
        if (imem_rsp_valid) begin
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_instr[i] <= '0;
        r_mem_pc[i]    <= '0;
      end
    end else if (EX_taken) begin
      // Empty the queue without moving the head, so D_instr/D_pc keep their value.
      r_tail  <= r_head;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem_instr[r_tail] <= imem_rsp_data;
        r_mem_pc[r_tail]    <= r_req_pc;
        r_tail              <= r_tail + AW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
